// File: rtl/debounce_cell.sv
// debounce_cell: single-bit synchronizer, debounce counter and edge pulses
module debounce_cell #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 120000,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
  typedef enum logic {STABLE, CHANGING} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] count, count_d;
  logic sync, differ, clean_d, rise_d, fall_d;
  assign sync = sync_q[SYNC_STAGES-1];
  assign differ = sync != clean_out;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      state <= STABLE;
      count <= '0;
      clean_out <= RESET_VALUE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      state <= state_d;
      count <= count_d;
      clean_out <= clean_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  // Any cycle where sync agrees with clean rejects the pending change
  always_comb begin
    state_d = state;
    count_d = count;
    clean_d = clean_out;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!differ) begin
      state_d = STABLE;
      count_d = '0;
    end else if (state == STABLE) begin
      state_d = CHANGING;
      count_d = CW'(1);
    end else if (count == LIMIT) begin
      state_d = STABLE;
      count_d = '0;
      clean_d = sync;
      rise_d = sync;
      fall_d = !sync;
    end else begin
      count_d = count + 1'b1;
    end
  end
endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-bit synchronize, debounce and edge-detect raw pins
module gpio_input_conditioner #(
  parameter int               WIDTH           = 3,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 120000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_cell #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE(RESET_VALUE[i])
    ) u_cell (
      .clock(clock),
      .reset(reset),
      .raw_in(raw_in[i]),
      .clean_out(clean_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end
endmodule
